// File: rtl/loader_sdram_bridge_if.sv
// Loader-to-SDRAM byte-write bus: loader requests in, aligned SDRAM write port out.
// The bridge uses the slave modport; the loader/SDRAM side uses master.
interface loader_sdram_bridge_if #(
   parameter int unsigned ADDR_W = 22
);
   logic              in_write;
   logic [ADDR_W-1:0] in_addr;
   logic [7:0]        in_data;
   logic              in_done;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;

   modport master (
      output in_write, in_addr, in_data, in_done,
      input  mem_write, mem_addr, mem_data
   );

   modport slave (
      input  in_write, in_addr, in_data, in_done,
      output mem_write, mem_addr, mem_data
   );
endinterface

// File: rtl/loader_sdram_bridge.sv
// Buffers loader byte writes in a small FIFO and replays them on the 1-in-4 SDRAM slot.
// Also qualifies load_done so it only rises once every buffered byte has been written.
module loader_sdram_bridge #(
   parameter int unsigned ADDR_W     = 22,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              slot,
   loader_sdram_bridge_if.slave bus,
   output logic              load_done,
   output logic              busy,
   output logic              overflow,
   output logic [ADDR_W-1:0] bytes_written
);

   localparam int unsigned Depth  = 1 << DEPTH_LOG2;
   localparam int unsigned PtrW   = DEPTH_LOG2 + 1;
   localparam int unsigned EntryW = ADDR_W + 8;

   logic [EntryW-1:0] fifo_q [Depth];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]   count;
   logic              empty, full;
   logic              push, pop, push_req;
   logic [EntryW-1:0] head;

   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_data_q, mem_data_d;
   logic              load_done_q, load_done_d;
   logic              overflow_q, overflow_d;
   logic              done_seen_q, done_seen_d;
   logic [ADDR_W-1:0] bytes_q, bytes_d;

   // Extra wrap bit on the pointers makes count == Depth distinguishable from empty.
   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (count == '0);
   assign full  = (count == PtrW'(Depth));
   assign head  = fifo_q[rd_ptr_q[DEPTH_LOG2-1:0]];

   // Pop uses the registered count only: a same-cycle push into an empty FIFO waits a slot.
   assign pop      = slot && !empty;
   assign push_req = bus.in_write && !load_done_q;
   assign push     = push_req && (!full || pop);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      load_done_d = load_done_q;
      overflow_d  = overflow_q;
      done_seen_d = done_seen_q | bus.in_done;
      bytes_d     = bytes_q;

      if (pop) begin
         rd_ptr_d    = rd_ptr_q + PtrW'(1);
         mem_write_d = 1'b1;
         mem_addr_d  = head[EntryW-1:8];
         mem_data_d  = head[7:0];
         bytes_d     = bytes_q + ADDR_W'(1);
      end else if (slot) begin
         mem_write_d = 1'b0;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end else if (push_req) begin
         overflow_d = 1'b1;
      end

      // Same edge that drops mem_write, so the final byte got its full slot period.
      if (slot && done_seen_q && empty && !bus.in_write) begin
         load_done_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         load_done_q <= 1'b0;
         overflow_q  <= 1'b0;
         done_seen_q <= 1'b0;
         bytes_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         load_done_q <= load_done_d;
         overflow_q  <= overflow_d;
         done_seen_q <= done_seen_d;
         bytes_q     <= bytes_d;
      end
   end

   // Storage needs no reset; the pointers define which entries are valid.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {bus.in_addr, bus.in_data};
      end
   end

   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_data  = mem_data_q;
   assign load_done     = load_done_q;
   assign overflow      = overflow_q;
   assign bytes_written = bytes_q;
   assign busy          = !empty || mem_write_q;

endmodule
